// File: rtl/restoring_divider.sv
// ---------------------------------------------------------------------------
// restoring_divider
//
// Sequential signed integer divider. One restoring iteration per clock on the
// operand magnitudes, followed by a sign-fixup cycle. The quotient truncates
// toward zero and a nonzero remainder takes the sign of the dividend.
// Divide-by-zero and the single overflow case (-2^(N-1) / -1) are flagged.
//
// Ports
//   clk_i          in   1          clock, rising edge
//   reset_ni       in   1          asynchronous reset, active low
//   start_i        in   1          request; only sampled while idle
//   dividend_i     in   DATA_SIZE  signed dividend, captured on accept
//   divisor_i      in   DATA_SIZE  signed divisor, captured on accept
//   quotient_o     out  DATA_SIZE  signed quotient (registered)
//   remainder_o    out  DATA_SIZE  signed remainder (registered)
//   busy_o         out  1          high while iterating and during sign fixup
//   valid_o        out  1          one-cycle pulse when results are written
//   div_by_zero_o  out  1          divisor was zero (registered with results)
//   overflow_o     out  1          -2^(N-1) / -1 case (registered with results)
//
// Latency: accept on edge 0, iterations on edges 1..DATA_SIZE, results on
// edge DATA_SIZE+1, valid_o high until edge DATA_SIZE+2, next accept no
// earlier than edge DATA_SIZE+3.
// ---------------------------------------------------------------------------
module restoring_divider #(
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 start_i,
   input  logic [DATA_SIZE-1:0] dividend_i,
   input  logic [DATA_SIZE-1:0] divisor_i,
   output logic [DATA_SIZE-1:0] quotient_o,
   output logic [DATA_SIZE-1:0] remainder_o,
   output logic                 busy_o,
   output logic                 valid_o,
   output logic                 div_by_zero_o,
   output logic                 overflow_o
);

   localparam int unsigned CW  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam int unsigned MSB = DATA_SIZE - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_sign_q;    // quotient negative
   logic                 r_sign_r;    // remainder takes dividend's sign
   logic                 r_ovf;       // operands were the overflow pair
   logic [DATA_SIZE-1:0] r_dvd_raw;   // raw dividend, returned on divide-by-zero
   logic [DATA_SIZE-1:0] r_dvr_mag;   // |divisor|
   logic [DATA_SIZE-1:0] r_q;         // starts as |dividend|, shifts into quotient
   logic [DATA_SIZE:0]   r_rem;       // partial remainder, one guard bit
   logic [CW-1:0]        r_count;

   logic [DATA_SIZE-1:0] w_dvd_mag;
   logic [DATA_SIZE-1:0] w_dvr_mag;
   logic                 w_ovf_case;
   logic [DATA_SIZE:0]   w_rem_sh;
   logic [DATA_SIZE:0]   w_diff;
   logic [DATA_SIZE-1:0] w_q_fix;
   logic [DATA_SIZE-1:0] w_rem_fix;

   // Magnitudes of the incoming operands. Negating -2^(N-1) yields the same
   // bit pattern, which read as unsigned is exactly 2^(N-1).
   always_comb begin
      w_dvd_mag  = dividend_i[MSB] ? ('0 - dividend_i) : dividend_i;
      w_dvr_mag  = divisor_i[MSB]  ? ('0 - divisor_i)  : divisor_i;
      w_ovf_case = (dividend_i == {1'b1, {(DATA_SIZE-1){1'b0}}}) &&
                   (divisor_i == '1);
   end

   // One restoring step: shift the MSB of q into the remainder, then trial
   // subtract. The guard bit of w_diff is the borrow, so it doubles as sign.
   // The partial remainder always stays below |divisor| <= 2^(N-1), so the
   // shifted value never overflows the N+1-bit width.
   always_comb begin
      w_rem_sh = (r_rem << 1) | (DATA_SIZE+1)'(r_q[MSB]);
      w_diff   = w_rem_sh - {1'b0, r_dvr_mag};
   end

   // Sign fixup applied on the SIGN edge.
   always_comb begin
      w_q_fix   = r_sign_q ? ('0 - r_q) : r_q;
      w_rem_fix = r_sign_r ? ('0 - r_rem[DATA_SIZE-1:0]) : r_rem[DATA_SIZE-1:0];
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state       <= IDLE;
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_ovf         <= 1'b0;
         r_dvd_raw     <= '0;
         r_dvr_mag     <= '0;
         r_q           <= '0;
         r_rem         <= '0;
         r_count       <= '0;
         quotient_o    <= '0;
         remainder_o   <= '0;
         busy_o        <= 1'b0;
         valid_o       <= 1'b0;
         div_by_zero_o <= 1'b0;
         overflow_o    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               valid_o <= 1'b0;
               if (start_i) begin
                  r_sign_q  <= dividend_i[MSB] ^ divisor_i[MSB];
                  r_sign_r  <= dividend_i[MSB];
                  r_ovf     <= w_ovf_case;
                  r_dvd_raw <= dividend_i;
                  r_dvr_mag <= w_dvr_mag;
                  r_q       <= w_dvd_mag;
                  r_rem     <= '0;
                  r_count   <= CW'(DATA_SIZE - 1);
                  busy_o    <= 1'b1;
                  r_state   <= CALC;
               end
            end

            CALC: begin
               if (!w_diff[DATA_SIZE]) begin
                  r_rem <= w_diff;
                  r_q   <= {r_q[DATA_SIZE-2:0], 1'b1};
               end else begin
                  r_rem <= w_rem_sh;
                  r_q   <= {r_q[DATA_SIZE-2:0], 1'b0};
               end
               r_count <= r_count - 1'b1;
               if (r_count == '0) begin
                  r_state <= SIGN;
               end
            end

            SIGN: begin
               if (r_dvr_mag == '0) begin
                  quotient_o    <= '1;
                  remainder_o   <= r_dvd_raw;
                  div_by_zero_o <= 1'b1;
                  overflow_o    <= 1'b0;
               end else begin
                  // The overflow pair naturally produces 2^(N-1) / 1 with a
                  // positive sign, i.e. the wrapped -2^(N-1) and remainder 0.
                  quotient_o    <= w_q_fix;
                  remainder_o   <= w_rem_fix;
                  div_by_zero_o <= 1'b0;
                  overflow_o    <= r_ovf;
               end
               busy_o  <= 1'b0;
               valid_o <= 1'b1;
               r_state <= DONE;
            end

            DONE: begin
               valid_o <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               busy_o  <= 1'b0;
               valid_o <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

   localparam int unsigned N = 8;

   logic         clk_i = 1'b0;
   logic         reset_ni;
   logic         start_i;
   logic [N-1:0] dividend_i;
   logic [N-1:0] divisor_i;
   logic [N-1:0] quotient_o;
   logic [N-1:0] remainder_o;
   logic         busy_o;
   logic         valid_o;
   logic         div_by_zero_o;
   logic         overflow_o;

   int n_checks = 0;
   int n_errors = 0;

   restoring_divider #(.DATA_SIZE(N)) u_dut (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .busy_o        (busy_o),
      .valid_o       (valid_o),
      .div_by_zero_o (div_by_zero_o),
      .overflow_o    (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division (SV '/' and '%' truncate toward zero).
   task automatic model(input int a, input int b,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic dz, output logic ov);
      int qi;
      int ri;
      dz = 1'b0;
      ov = 1'b0;
      if (b == 0) begin
         qi = -1;
         ri = a;
         dz = 1'b1;
      end else if (a == -128 && b == -1) begin
         qi = -128;
         ri = 0;
         ov = 1'b1;
      end else begin
         qi = a / b;
         ri = a % b;
      end
      q = qi[N-1:0];
      r = ri[N-1:0];
   endtask

   // One full operation from an idle DUT. Returns one cycle after valid_o
   // falls, with the DUT idle and ready to accept on the next edge.
   task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit perturb, input bit mid_pulse);
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ez;
      logic         eo;
      int           lat;
      model(int'($signed(a)), int'($signed(b)), eq, er, ez, eo);
      @(negedge clk_i);
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (perturb) begin
         dividend_i = N'($urandom);
         divisor_i  = N'($urandom);
      end
      check("busy_edge0", 32'(busy_o), 32'd1);
      lat = 0;
      while (!valid_o && lat < 20) begin
         if (mid_pulse && lat == 2) start_i = 1'b1;
         if (mid_pulse && lat == 3) start_i = 1'b0;
         @(posedge clk_i);
         #1;
         lat++;
         if (!valid_o) check("busy_calc", 32'(busy_o), 32'd1);
      end
      start_i = 1'b0;
      check("latency", 32'(lat), 32'd9);
      check("busy_done", 32'(busy_o), 32'd0);
      check("quotient", 32'(quotient_o), 32'(eq));
      check("remainder", 32'(remainder_o), 32'(er));
      check("div_by_zero", 32'(div_by_zero_o), 32'(ez));
      check("overflow", 32'(overflow_o), 32'(eo));
      @(posedge clk_i);
      #1;
      check("valid_pulse", 32'(valid_o), 32'd0);
      check("quotient_hold", 32'(quotient_o), 32'(eq));
   endtask

   initial begin
      logic [N-1:0] eq;
      logic [N-1:0] er;
      logic         ez;
      logic         eo;
      int           vcyc[$];
      int           seen;
      bit           drained;

      reset_ni   = 1'b0;
      start_i    = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      #12;
      check("rst_quotient", 32'(quotient_o), 32'd0);
      check("rst_remainder", 32'(remainder_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_flags", 32'({div_by_zero_o, overflow_o}), 32'd0);
      @(negedge clk_i);
      reset_ni = 1'b1;

      // Directed cases.
      do_div(8'd100, 8'd7, 1'b0, 1'b0);
      do_div(8'h9C, 8'd7, 1'b0, 1'b0);     // -100 / 7
      do_div(8'd100, 8'hF9, 1'b0, 1'b0);   // 100 / -7
      do_div(8'h9C, 8'hF9, 1'b0, 1'b0);    // -100 / -7
      do_div(8'h80, 8'hFF, 1'b0, 1'b0);    // -128 / -1
      do_div(8'h80, 8'd1, 1'b0, 1'b0);     // -128 / 1
      do_div(8'd7, 8'd9, 1'b0, 1'b0);
      do_div(8'd5, 8'd0, 1'b0, 1'b0);      // divide by zero
      do_div(8'd100, 8'd7, 1'b0, 1'b0);    // flag cleared again
      do_div(8'h80, 8'd0, 1'b0, 1'b0);
      do_div(8'h7F, 8'h80, 1'b0, 1'b0);

      // Operands changed after accept must not matter.
      do_div(8'd100, 8'd7, 1'b1, 1'b0);

      // Start pulsed mid-CALC is ignored: no second operation follows.
      do_div(8'd77, 8'd5, 1'b0, 1'b1);
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk_i);
         #1;
         if (valid_o || busy_o) seen++;
      end
      check("ignored_start", 32'(seen), 32'd0);

      // Start held high: back-to-back operations 11 cycles apart.
      model(-100, 7, eq, er, ez, eo);
      @(negedge clk_i);
      dividend_i = 8'h9C;
      divisor_i  = 8'd7;
      start_i    = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(posedge clk_i);
         #1;
         if (valid_o) begin
            vcyc.push_back(c);
            check("b2b_quotient", 32'(quotient_o), 32'(eq));
            check("b2b_remainder", 32'(remainder_o), 32'(er));
         end
      end
      start_i = 1'b0;
      check("b2b_count", 32'(vcyc.size()), 32'd3);
      if (vcyc.size() >= 2) check("b2b_gap", 32'(vcyc[1] - vcyc[0]), 32'd11);
      if (vcyc.size() >= 3) check("b2b_gap2", 32'(vcyc[2] - vcyc[1]), 32'd11);
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         @(posedge clk_i);
         #1;
         if (!busy_o && !valid_o) drained = 1'b1;
      end
      check("b2b_drain", 32'(drained), 32'd1);
      @(posedge clk_i);
      #1;

      // Randomized operations, biased toward corner operands.
      for (int i = 0; i < 60; i++) begin
         logic [N-1:0] a;
         logic [N-1:0] b;
         a = N'($urandom);
         b = N'($urandom);
         case ($urandom_range(0, 7))
            0: b = '0;
            1: a = 8'h80;
            2: b = 8'hFF;
            3: b = N'($urandom_range(1, 3));
            default: ;
         endcase
         do_div(a, b, ($urandom_range(0, 1) == 1), 1'b0);
      end

      // Reset asserted in the 4th CALC cycle aborts with no valid pulse.
      @(negedge clk_i);
      dividend_i = 8'd100;
      divisor_i  = 8'd7;
      start_i    = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      reset_ni = 1'b0;
      #1;
      check("abort_quotient", 32'(quotient_o), 32'd0);
      check("abort_remainder", 32'(remainder_o), 32'd0);
      check("abort_busy_valid", 32'({busy_o, valid_o}), 32'd0);
      check("abort_flags", 32'({div_by_zero_o, overflow_o}), 32'd0);
      repeat (2) @(negedge clk_i);
      reset_ni = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i);
         #1;
         if (valid_o) seen++;
      end
      check("abort_no_valid", 32'(seen), 32'd0);
      do_div(8'd100, 8'd7, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
